// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl
//   Run controller that sits between a simulation bench and a CPU core.
//   It holds the core in reset for a fixed number of clocks, then lets it run.
//   While running it counts cycles and retired instructions.
//   A run ends in one of two ways:
//     - a halt (ebreak/ecall, or a tohost write when monitoring is enabled),
//       followed by a short drain so in-flight instructions can retire;
//     - a timeout once the cycle budget is spent.
//   Every output is registered. Results stay put until the next reset.
//
// Ports
//   clock          in   rising-edge clock
//   reset          in   synchronous, active-high; dominates every state
//   instr_retired  in   one pulse per retired instruction
//   halt_req       in   ebreak/ecall decoded this cycle
//   halt_code      in   exit value (a0), taken together with halt_req
//   mem_we         in   data-memory write strobe
//   mem_addr       in   data-memory write address
//   mem_wdata      in   data-memory write data
//   cpu_reset      out  active-high reset to the core; also freezes it once done
//   done           out  run finished (sticky until reset)
//   pass           out  done, exit_code == 0 and no timeout
//   timeout        out  cycle budget reached without a halt
//   exit_code      out  latched exit value
//   cycle_count    out  RUN cycles elapsed (saturating)
//   instret_count  out  instructions retired in RUN and DRAIN (saturating)
//
// Build option
//   TOHOST_MON_EN  when defined, a RUN-state write to TOHOST_ADDR with
//                  mem_wdata[0]==1 also halts, with exit code mem_wdata>>1.
//                  A halt_req in the same cycle takes priority.
//                  When undefined, the mem_* inputs are ignored.
//
// state   | meaning
// S_RST   | core held in reset; counts down the reset hold
// S_RUN   | core running; cycle budget consumed
// S_DRAIN | halt seen; cycle count frozen, retirements still counted
// S_DONE  | result latched; core frozen until reset

module cpu_run_ctrl #(
  parameter int              XLEN         = 32,
  parameter int              CNT_W        = 32,
  parameter int              RESET_CYCLES = 2,
  parameter int              MAX_CYCLES   = 1000,
  parameter int              DRAIN_CYCLES = 4,
  parameter logic [XLEN-1:0] TOHOST_ADDR  = 32'h00001000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             instr_retired,
  input  logic             halt_req,
  input  logic [XLEN-1:0]  halt_code,
  input  logic             mem_we,
  input  logic [XLEN-1:0]  mem_addr,
  input  logic [XLEN-1:0]  mem_wdata,
  output logic             cpu_reset,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [XLEN-1:0]  exit_code,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret_count
);

  // A zero reset hold would skip the core reset altogether, so clamp to one.
  localparam int RST_LOAD = (RESET_CYCLES < 1) ? 1 : RESET_CYCLES;
  localparam int RST_W    = $clog2(RST_LOAD + 1);
  localparam int DRN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [RST_W-1:0] RST_INIT  = RST_W'(RST_LOAD);
  // Drain timer reaches terminal count on its last DRAIN clock.
  localparam logic [DRN_W-1:0] DRN_INIT  = DRN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CYC_LIMIT = CNT_W'(MAX_CYCLES);

  typedef enum logic [1:0] {
    S_RST   = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic [DRN_W-1:0]  drn_cnt_q, drn_cnt_d;

  logic              cpu_reset_d, done_d, pass_d, timeout_d;
  logic [XLEN-1:0]   exit_code_d;
  logic [CNT_W-1:0]  cycle_count_d, instret_count_d;
  logic [CNT_W-1:0]  cycle_inc, instret_inc;

  logic              halt_hit;
  logic [XLEN-1:0]   halt_val;

`ifdef TOHOST_MON_EN
  logic tohost_hit;

  // Odd tohost values end the run; even values are ordinary mailbox traffic.
  always_comb begin
    tohost_hit = mem_we && (mem_addr == TOHOST_ADDR) && mem_wdata[0];
    halt_hit   = halt_req || tohost_hit;
    halt_val   = halt_req ? halt_code : (mem_wdata >> 1);
  end
`else
  logic unused_mem;

  assign unused_mem = &{1'b0, mem_we, mem_addr, mem_wdata, TOHOST_ADDR};
  assign halt_hit   = halt_req;
  assign halt_val   = halt_code;
`endif

  // Counters stick at all-ones instead of wrapping.
  assign cycle_inc   = (cycle_count == '1)   ? cycle_count   : cycle_count + CNT_W'(1);
  assign instret_inc = (instret_count == '1) ? instret_count : instret_count + CNT_W'(1);

  always_comb begin
    state_d         = state_q;
    rst_cnt_d       = rst_cnt_q;
    drn_cnt_d       = drn_cnt_q;
    cpu_reset_d     = cpu_reset;
    done_d          = done;
    pass_d          = pass;
    timeout_d       = timeout;
    exit_code_d     = exit_code;
    cycle_count_d   = cycle_count;
    instret_count_d = instret_count;

    case (state_q)
      S_RST: begin
        if (rst_cnt_q == '0) begin
          state_d     = S_RUN;
          cpu_reset_d = 1'b0;
        end else begin
          rst_cnt_d = rst_cnt_q - RST_W'(1);
        end
      end

      S_RUN: begin
        cycle_count_d = cycle_inc;
        if (instr_retired) begin
          instret_count_d = instret_inc;
        end
        // A halt on the budget's last cycle still counts as a halt.
        if (halt_hit) begin
          exit_code_d = halt_val;
          if (DRAIN_CYCLES == 0) begin
            state_d     = S_DONE;
            done_d      = 1'b1;
            cpu_reset_d = 1'b1;
            pass_d      = (halt_val == '0);
          end else begin
            state_d   = S_DRAIN;
            drn_cnt_d = DRN_INIT;
          end
        end else if (cycle_inc == CYC_LIMIT) begin
          state_d     = S_DONE;
          done_d      = 1'b1;
          cpu_reset_d = 1'b1;
          timeout_d   = 1'b1;
          pass_d      = 1'b0;
        end
      end

      S_DRAIN: begin
        if (instr_retired) begin
          instret_count_d = instret_inc;
        end
        if (drn_cnt_q == '0) begin
          state_d     = S_DONE;
          done_d      = 1'b1;
          cpu_reset_d = 1'b1;
          pass_d      = (exit_code == '0);
        end else begin
          drn_cnt_d = drn_cnt_q - DRN_W'(1);
        end
      end

      S_DONE: begin
      end

      default: begin
        state_d = S_RST;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_RST;
      rst_cnt_q     <= RST_INIT;
      drn_cnt_q     <= '0;
      cpu_reset     <= 1'b1;
      done          <= 1'b0;
      pass          <= 1'b0;
      timeout       <= 1'b0;
      exit_code     <= '0;
      cycle_count   <= '0;
      instret_count <= '0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      drn_cnt_q     <= drn_cnt_d;
      cpu_reset     <= cpu_reset_d;
      done          <= done_d;
      pass          <= pass_d;
      timeout       <= timeout_d;
      exit_code     <= exit_code_d;
      cycle_count   <= cycle_count_d;
      instret_count <= instret_count_d;
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: per-cycle stimulus tables are filled (directed
// plus $urandom), a run-level model derives the outcome of each run from
// the tables, and the DUT is compared at the end of each run.

module tb_cpu_run_ctrl;

  localparam int          XLEN         = 32;
  localparam int          CNT_W        = 32;
  localparam int          RESET_CYCLES = 2;
  localparam int          MAX_CYCLES   = 50;
  localparam int          DRAIN_CYCLES = 4;
  localparam logic [31:0] TOHOST       = 32'h00001000;
  localparam int          NCYC         = 64;

`ifdef TOHOST_MON_EN
  localparam bit TOHOST_EN = 1'b1;
`else
  localparam bit TOHOST_EN = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             instr_retired = 1'b0;
  logic             halt_req = 1'b0;
  logic [XLEN-1:0]  halt_code = '0;
  logic             mem_we = 1'b0;
  logic [XLEN-1:0]  mem_addr = '0;
  logic [XLEN-1:0]  mem_wdata = '0;
  logic             cpu_reset, done, pass, timeout;
  logic [XLEN-1:0]  exit_code;
  logic [CNT_W-1:0] cycle_count, instret_count;

  always #5 clock = ~clock;

  cpu_run_ctrl #(
    .XLEN(XLEN), .CNT_W(CNT_W), .RESET_CYCLES(RESET_CYCLES),
    .MAX_CYCLES(MAX_CYCLES), .DRAIN_CYCLES(DRAIN_CYCLES), .TOHOST_ADDR(TOHOST)
  ) dut (
    .clock(clock), .reset(reset), .instr_retired(instr_retired),
    .halt_req(halt_req), .halt_code(halt_code), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_reset(cpu_reset),
    .done(done), .pass(pass), .timeout(timeout), .exit_code(exit_code),
    .cycle_count(cycle_count), .instret_count(instret_count)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Stimulus tables indexed by RUN cycle number (1 = first RUN cycle).
  bit          ret_p   [1:NCYC];
  bit          hreq_p  [1:NCYC];
  logic [31:0] hcode_p [1:NCYC];
  bit          we_p    [1:NCYC];
  logic [31:0] addr_p  [1:NCYC];
  logic [31:0] wdata_p [1:NCYC];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    instr_retired = 1'b0;
    halt_req      = 1'b0;
    halt_code     = '0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
  endtask

  // halt_at = 0 means no halt_req at all; later cycles get random halts that
  // must be ignored. Random write data is even, so only directed entries can
  // form a tohost halt.
  task automatic fill(input int halt_at, input logic [31:0] code, input bit ten_ret);
    for (int k = 1; k <= NCYC; k++) begin
      ret_p[k]   = ten_ret ? (k <= 10) : 1'($urandom_range(0, 1));
      hreq_p[k]  = (k == halt_at) ? 1'b1
                 : ((halt_at > 0) && (k > halt_at)) ? 1'($urandom_range(0, 1)) : 1'b0;
      hcode_p[k] = (k == halt_at) ? code : 32'($urandom);
      we_p[k]    = 1'($urandom_range(0, 1));
      addr_p[k]  = ($urandom_range(0, 3) == 0) ? TOHOST : 32'($urandom);
      wdata_p[k] = 32'($urandom) & 32'hFFFF_FFFE;
    end
  endtask

  task automatic set_write(input int k, input logic [31:0] data);
    we_p[k]    = 1'b1;
    addr_p[k]  = TOHOST;
    wdata_p[k] = data;
  endtask

  // Outcome of one run from the tables: find the first halt inside the
  // budget; the run then lasts through the drain window, else until budget.
  task automatic model(output int done_at, output logic [31:0] e_cyc,
                       output logic [31:0] e_ins, output logic [31:0] e_exit,
                       output bit e_to, output bit e_pass);
    int h;
    logic [31:0] code;
    h = 0;
    code = '0;
    for (int k = 1; (k <= MAX_CYCLES) && (h == 0); k++) begin
      if (hreq_p[k]) begin
        h = k;
        code = hcode_p[k];
      end else if (TOHOST_EN && we_p[k] && (addr_p[k] == TOHOST) && wdata_p[k][0]) begin
        h = k;
        code = wdata_p[k] >> 1;
      end
    end
    if (h != 0) begin
      done_at = h + DRAIN_CYCLES;
      e_cyc   = 32'(h);
      e_exit  = code;
      e_to    = 1'b0;
    end else begin
      done_at = MAX_CYCLES;
      e_cyc   = 32'(MAX_CYCLES);
      e_exit  = '0;
      e_to    = 1'b1;
    end
    e_ins = '0;
    for (int k = 1; k <= done_at; k++) e_ins += 32'(ret_p[k]);
    e_pass = !e_to && (e_exit == 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".cpu_reset"}, cpu_reset, 1);
    check({tag, ".done"}, done, 0);
    check({tag, ".pass"}, pass, 0);
    check({tag, ".timeout"}, timeout, 0);
    check({tag, ".exit_code"}, exit_code, 0);
    check({tag, ".cycle_count"}, cycle_count, 0);
    check({tag, ".instret_count"}, instret_count, 0);
  endtask

  // Starts and ends at a negedge; on return the DUT is in its first RUN cycle.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clock);
    check_reset_state({tag, ".held"});
    reset = 1'b0;
    @(negedge clock);
    check({tag, ".rel1.cpu_reset"}, cpu_reset, 1);
    check({tag, ".rel1.done"}, done, 0);
    @(negedge clock);
    check({tag, ".rel2.cpu_reset"}, cpu_reset, 1);
    @(negedge clock);
    check({tag, ".rel3.cpu_reset"}, cpu_reset, 0);
    check({tag, ".rel3.done"}, done, 0);
  endtask

  task automatic run(input string tag, input int abort_at);
    int          e_done_at, seen, bad;
    logic [31:0] e_cyc, e_ins, e_exit;
    bit          e_to, e_pass, aborted;
    model(e_done_at, e_cyc, e_ins, e_exit, e_to, e_pass);
    seen = 0;
    bad = 0;
    aborted = 1'b0;
    for (int k = 1; (k <= NCYC) && (seen == 0) && !aborted; k++) begin
      if (k == abort_at) begin
        check({tag, ".drain.cycle_count"}, cycle_count, e_cyc);
        check({tag, ".drain.exit_code"}, exit_code, e_exit);
        check({tag, ".drain.done"}, done, 0);
        reset = 1'b1;
        idle_inputs();
        @(negedge clock);
        check_reset_state({tag, ".abort"});
        aborted = 1'b1;
      end else begin
        instr_retired = ret_p[k];
        halt_req      = hreq_p[k];
        halt_code     = hcode_p[k];
        mem_we        = we_p[k];
        mem_addr      = addr_p[k];
        mem_wdata     = wdata_p[k];
        @(negedge clock);
        if (done === 1'b1) seen = k;
        else if (cpu_reset !== 1'b0) bad++;
      end
    end
    if (!aborted) begin
      check({tag, ".done_cycle"}, 64'(seen), 64'(e_done_at));
      check({tag, ".cpu_reset_low_in_run"}, 64'(bad), 0);
      check({tag, ".done"}, done, 1);
      check({tag, ".cpu_reset"}, cpu_reset, 1);
      check({tag, ".pass"}, pass, e_pass);
      check({tag, ".timeout"}, timeout, e_to);
      check({tag, ".exit_code"}, exit_code, e_exit);
      check({tag, ".cycle_count"}, cycle_count, e_cyc);
      check({tag, ".instret_count"}, instret_count, e_ins);
      repeat (5) begin
        instr_retired = 1'b1;
        halt_req      = 1'b1;
        halt_code     = 32'($urandom);
        mem_we        = 1'b1;
        mem_addr      = TOHOST;
        mem_wdata     = 32'($urandom) | 32'h1;
        @(negedge clock);
      end
      check({tag, ".hold.done"}, done, 1);
      check({tag, ".hold.pass"}, pass, e_pass);
      check({tag, ".hold.exit_code"}, exit_code, e_exit);
      check({tag, ".hold.cycle_count"}, cycle_count, e_cyc);
      check({tag, ".hold.instret_count"}, instret_count, e_ins);
      idle_inputs();
    end
  endtask

  initial begin
    int          h;
    logic [31:0] c;

    do_reset("rst_a");
    fill(12, 32'd0, 1'b1);
    run("halt_code0", 0);

    do_reset("rst_b");
    fill(int'($urandom_range(5, 40)), 32'd3, 1'b0);
    run("halt_code3", 0);

    do_reset("rst_c");
    fill(0, 32'd0, 1'b0);
    run("timeout", 0);

    do_reset("rst_d");
    fill(MAX_CYCLES, 32'd0, 1'b0);
    run("halt_at_budget", 0);

    do_reset("rst_e");
    fill(0, 32'd0, 1'b0);
    set_write(7, 32'd1);
    run("tohost_1", 0);

    do_reset("rst_f");
    fill(0, 32'd0, 1'b0);
    set_write(9, 32'd7);
    run("tohost_7", 0);

    do_reset("rst_g");
    fill(20, 32'd0, 1'b0);
    set_write(5, 32'd6);
    run("tohost_6", 0);

    do_reset("rst_h");
    fill(15, 32'd9, 1'b0);
    set_write(15, 32'd1);
    run("tohost_vs_halt", 0);

    do_reset("rst_i");
    fill(8, 32'd5, 1'b0);
    run("abort_drain", 10);

    do_reset("rst_j");
    fill(12, 32'd0, 1'b1);
    run("after_abort", 0);

    for (int r = 0; r < 6; r++) begin
      h = int'($urandom_range(1, 60));
      c = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom);
      do_reset($sformatf("rst_rand%0d", r));
      fill(h, c, 1'b0);
      run($sformatf("rand%0d", r), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
